// File: rtl/fault_recovery_controller.sv
// Fault recovery controller: freezes, rolls the PC back to a checkpoint and resumes on a fault,
// escalating to a sticky HALT when faults recur before the retry count has been cleared by a quiet window.
module fault_recovery_controller #(
  parameter int                    NUM_FAULTS    = 3,
  parameter logic [NUM_FAULTS-1:0] CRIT_MASK     = 3'b100,
  parameter int                    MAX_RETRIES   = 2,
  parameter int                    FREEZE_CYCLES = 4,
  parameter int                    QUIET_CYCLES  = 16,
  parameter int                    XLEN          = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_FAULTS-1:0] fault_in,
  input  logic                  clear_halt,
  input  logic                  pc_write_normal,
  input  logic                  reg_write_normal,
  input  logic                  mem_write_normal,
  input  logic [XLEN-1:0]       pc_current,
  input  logic [XLEN-1:0]       pc_saved,
  output logic                  pc_write_out,
  output logic                  reg_write_out,
  output logic                  mem_write_out,
  output logic [XLEN-1:0]       pc_next,
  output logic                  insert_nop,
  output logic                  retry_en,
  output logic                  halted,
  output logic [2:0]            fsm_state,
  output logic [3:0]            retry_cnt,
  output logic [NUM_FAULTS-1:0] fault_cause,
  output logic [NUM_FAULTS-1:0] fault_log,
  output logic [7:0]            fault_count
);

  localparam int FW = $clog2(FREEZE_CYCLES + 1);
  localparam int QW = $clog2(QUIET_CYCLES + 1);
  localparam logic [FW-1:0] FREEZE_LOAD = FW'(FREEZE_CYCLES - 1);
  localparam logic [QW-1:0] QUIET_LAST  = QW'(QUIET_CYCLES - 1);
  localparam logic [3:0]    RETRY_LIMIT = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_NORMAL  = 3'd0,
    S_FREEZE  = 3'd1,
    S_RECOVER = 3'd2,
    S_RESUME  = 3'd3,
    S_HALT    = 3'd4
  } state_t;

  state_t                r_state;
  state_t                w_nextState;
  logic [3:0]            r_retryCnt;
  logic [QW-1:0]         r_quietCnt;
  logic [FW-1:0]         r_freezeCnt;
  logic [NUM_FAULTS-1:0] r_faultCause;
  logic [NUM_FAULTS-1:0] r_faultLog;
  logic [7:0]            r_faultCount;
  logic                  w_anyFault;
  logic                  w_crit;
  logic                  w_detect;

  assign w_anyFault = |fault_in;
  assign w_crit     = |(fault_in & CRIT_MASK);
  assign w_detect   = (r_state == S_NORMAL) && w_anyFault;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_NORMAL;
    else       r_state <= w_nextState;
  end

  // Write gating in NORMAL depends on fault_in directly so a fault blocks writes in its own cycle.
  always_comb begin
    w_nextState   = r_state;
    pc_write_out  = 1'b0;
    reg_write_out = 1'b0;
    mem_write_out = 1'b0;
    pc_next       = pc_current;
    insert_nop    = 1'b0;
    retry_en      = 1'b0;
    halted        = 1'b0;
    case (r_state)
      S_NORMAL: begin
        if (!w_anyFault) begin
          pc_write_out  = pc_write_normal;
          reg_write_out = reg_write_normal;
          mem_write_out = mem_write_normal;
        end else if (r_retryCnt == RETRY_LIMIT) begin
          w_nextState = S_HALT;
        end else if (w_crit) begin
          w_nextState = S_FREEZE;
        end else begin
          w_nextState = S_RECOVER;
        end
      end
      S_FREEZE: begin
        if (r_freezeCnt == '0) w_nextState = S_RECOVER;
      end
      S_RECOVER: begin
        pc_next      = pc_saved;
        pc_write_out = 1'b1;
        insert_nop   = 1'b1;
        retry_en     = 1'b1;
        w_nextState  = S_RESUME;
      end
      S_RESUME: begin
        insert_nop  = 1'b1;
        w_nextState = S_NORMAL;
      end
      S_HALT: begin
        insert_nop = 1'b1;
        halted     = 1'b1;
        if (clear_halt) w_nextState = S_NORMAL;
      end
      default: w_nextState = S_NORMAL;
    endcase
  end

  // Retry increments on entry to RECOVER; the quiet window and clear_halt are the only ways back to zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_retryCnt   <= '0;
      r_quietCnt   <= '0;
      r_freezeCnt  <= '0;
      r_faultCause <= '0;
      r_faultLog   <= '0;
      r_faultCount <= '0;
    end else begin
      r_faultLog <= r_faultLog | fault_in;
      if (w_detect) begin
        r_faultCause <= fault_in;
        r_quietCnt   <= '0;
        if (r_faultCount != 8'hFF) r_faultCount <= r_faultCount + 8'd1;
      end else if (r_state == S_NORMAL) begin
        if (r_quietCnt == QUIET_LAST) begin
          r_quietCnt <= '0;
          r_retryCnt <= '0;
        end else begin
          r_quietCnt <= r_quietCnt + QW'(1);
        end
      end
      if (r_state == S_HALT && clear_halt) begin
        r_retryCnt <= '0;
        r_quietCnt <= '0;
      end
      if (w_nextState == S_RECOVER && r_state != S_RECOVER) r_retryCnt <= r_retryCnt + 4'd1;
      if (w_nextState == S_FREEZE && r_state != S_FREEZE) r_freezeCnt <= FREEZE_LOAD;
      else if (r_state == S_FREEZE && r_freezeCnt != '0) r_freezeCnt <= r_freezeCnt - FW'(1);
    end
  end

  assign fsm_state   = r_state;
  assign retry_cnt   = r_retryCnt;
  assign fault_cause = r_faultCause;
  assign fault_log   = r_faultLog;
  assign fault_count = r_faultCount;

endmodule
